// File: rtl/sync_fifo_flex.sv
// Single-clock circular-buffer FIFO for any DEPTH. It provides an occupancy count,
// programmable almost flags, overflow/underflow pulses and an optional FWFT read port.
module sync_fifo_flex #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 64,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = 0,
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [31:0]   AF_U    = 32'(AF_LEVEL);
    localparam logic [31:0]   AE_U    = 32'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             wr_ok;
    logic             rd_ok;

    // Pointers wrap explicitly so that a non-power-of-two DEPTH never indexes past the end.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // A full FIFO can still take a write in the same cycle that a read frees a slot.
    assign rd_ok = read && (count_q != '0);
    assign wr_ok = write && ((count_q != DEPTH_C) || rd_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= ptr_next(wr_ptr);
            if (rd_ok) rd_ptr <= ptr_next(rd_ptr);
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            overflow  <= write && !wr_ok;
            underflow <= read && !rd_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= data_in;
    end

    // The flags decode only the registered count, so read/write never reach them combinationally.
    assign count        = count_q;
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (32'(count_q) >= AF_U);
    assign almost_empty = (32'(count_q) <= AE_U);

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = empty ? '0 : mem[rd_ptr];
        end else begin : g_std
            logic [WIDTH-1:0] dout_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)        dout_q <= '0;
                else if (rd_ok) dout_q <= mem[rd_ptr];
            end
            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
- Parametrised single-clock FIFO. Successor to the team's basic queue FIFO.
- Circular-buffer storage with read/write pointers that wrap at any DEPTH, not only powers of two.
- Adds an occupancy count, programmable almost-full and almost-empty flags, overflow and underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between producer and consumer datapaths in the same clock domain.

Parameters:
- WIDTH, 8: data word width in bits (≥1).
- DEPTH, 64: number of entries (≥2, any integer).
- AF_LEVEL, DEPTH-4: almost_full asserts when count ≥ AF_LEVEL.
- AE_LEVEL, 4: almost_empty asserts when count ≤ AE_LEVEL.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.
- CW, $clog2(DEPTH+1): width of count (derived; do not override).

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous active-high reset.
- write, input, 1: write request.
- data_in, input, WIDTH: write data.
- read, input, 1: read request.
- data_out, output, WIDTH: read data.
- full, output, 1: count == DEPTH.
- empty, output, 1: count == 0.
- almost_full, output, 1: count ≥ AF_LEVEL.
- almost_empty, output, 1: count ≤ AE_LEVEL.
- count, output, CW: current occupancy.
- overflow, output, 1: one-cycle pulse, a write was rejected.
- underflow, output, 1: one-cycle pulse, a read was rejected.

Behaviour:
- Reset: single clock (clk); rst is asynchronous and active-high.
  - While rst = 1: wr_ptr = rd_ptr = 0, count = 0, data_out = 0, overflow = underflow = 0.
  - Flags during reset: empty = 1, full = 0, almost_empty = 1, almost_full = (AF_LEVEL == 0).
  - Memory contents are not reset. Reset mid-operation discards all stored data immediately.
- Accept rules, evaluated on the pre-edge state:
  - wr_ok = write && (!full || read_ok).
  - read_ok = read && !empty.
  - Full with both read and write asserted: both accepted, count unchanged.
  - Empty with both asserted: write accepted, read rejected (underflow pulses), count goes to 1.
- Pointers:
  - On wr_ok, mem[wr_ptr] <= data_in.
  - Each pointer increments on accept and wraps DEPTH-1 → 0.
  - count += wr_ok - read_ok. It is never < 0 or > DEPTH.
- Flags are registered or decoded from registered count and are valid the cycle after an accepted operation.
  - full, empty, almost_full and almost_empty are all pure functions of count.
- Standard mode (FWFT = 0):
  - On read_ok, data_out <= mem[rd_ptr]. Read latency is 1 cycle.
  - data_out holds its last value when no read is accepted.
- FWFT mode (FWFT = 1):
  - data_out = mem[rd_ptr] combinationally whenever !empty; read acts as acknowledge and advances rd_ptr.
  - data_out = 0 when empty.
  - A word written into an empty FIFO is visible on data_out the cycle after the write edge.
- Errors:
  - overflow <= write && !wr_ok. Data is dropped; state is unchanged.
  - underflow <= read && !read_ok. data_out is unchanged in standard mode.
  - Both are one-cycle registered pulses and are not sticky.
- No combinational path from read/write to full/empty/count.
- Order is strict FIFO: first written word is first read.

Test Plan:
- Reset and fill, DEPTH = 8, FWFT = 0. Pulse rst, write 0x01..0x08 on consecutive cycles -> count 1..8; almost_full at count ≥ 4 (AF_LEVEL = 4); full = 1 after the 8th write. A 9th write gives overflow = 1 for one cycle, count stays 8.
- Drain, DEPTH = 8, FWFT = 0. From full, assert read 8 cycles -> data_out = 0x01..0x08, each 1 cycle after its read. empty = 1 after the last read. One more read gives underflow pulse, data_out stays 0x08.
- Wrap-around, DEPTH = 5 (non-power-of-2). Interleave 3 writes and 3 reads, 4 times, with incrementing data -> output order matches input with no gaps or duplicates across pointer wrap 4 → 0.
- Simultaneous events, DEPTH = 8. Full with read+write (0xAA) -> count stays 8, 0xAA emerges after the 7 older words. Empty with read+write (0x55) -> underflow pulse, count = 1.
- FWFT = 1. Write 0x3C into empty -> next cycle data_out = 0x3C with no read. Assert read -> empty = 1 and data_out = 0.
- Async reset mid-stream. Assert rst between clock edges with count = 5 -> count = 0, empty = 1 and data_out = 0 immediately, before the next clk edge.
